// File: rtl/piso_pkg.sv
// Shared FSM state encoding and the width helper for the serializer.
package piso_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
    } state_e;

    // Ceiling log2 for elaboration-time widths; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-word holding buffer; fills on load when empty, empties when the serializer takes it.
module piso_hold_buf #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             take,
    output logic [WIDTH-1:0] hold,
    output logic             hold_valid
);

    // take only fires while full, so it can never coincide with an accepted load.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (take) begin
            hold_valid <= 1'b0;
        end else if (load && !hold_valid) begin
            hold       <= din;
            hold_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: buffers one word and shifts it out with a first-bit frame marker.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             dataout,
    output logic             frame,
    output logic             busy
);

    localparam int unsigned   CntW    = clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);
    localparam logic [3:0]    GapLast = 4'(GAP);

    state_e             state;
    logic [CntW-1:0]    cnt;
    logic [3:0]         gap_cnt;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   hold;
    logic               hold_valid;
    logic               take;
    logic               word_done;
    logic               gap_done;
    logic               first_bit;
    logic               next_bit;

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk        (clk),
        .clear      (clear),
        .din        (din),
        .load       (load),
        .take       (take),
        .hold       (hold),
        .hold_valid (hold_valid)
    );

    always_comb begin
        ready     = ~hold_valid;
        word_done = (state == StShift) && (cnt == CntLast);
        gap_done  = (state == StGap) && (gap_cnt >= GapLast);
        // A reload happens from idle, after the gap, or straight off the last bit when GAP is 0.
        take      = hold_valid &&
                    ((state == StIdle) || gap_done || (word_done && (GAP == 0)));
        first_bit = MSB_FIRST ? hold[WIDTH-1] : hold[0];
        next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state   <= StIdle;
            cnt     <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            dataout <= 1'b0;
            frame   <= 1'b0;
            busy    <= 1'b0;
        end else if (take) begin
            state   <= StShift;
            shreg   <= hold;
            cnt     <= CntW'(1);
            gap_cnt <= '0;
            dataout <= first_bit;
            frame   <= 1'b1;
            busy    <= 1'b1;
        end else begin
            unique case (state)
                StShift: begin
                    frame <= 1'b0;
                    if (cnt != CntLast) begin
                        dataout <= next_bit;
                        shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                        cnt     <= cnt + CntW'(1);
                    end else begin
                        dataout <= 1'b0;
                        busy    <= 1'b0;
                        if (GAP != 0) begin
                            state   <= StGap;
                            gap_cnt <= 4'd1;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                StGap: begin
                    dataout <= 1'b0;
                    frame   <= 1'b0;
                    busy    <= 1'b0;
                    if (gap_done) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                StIdle: begin
                    dataout <= 1'b0;
                    frame   <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= StIdle;
                    dataout <= 1'b0;
                    frame   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: expected bits are queued when a word is loaded and popped while busy is high.
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic f;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] din;
    logic       load, ready, dataout, frame, busy;
    logic [7:0] din8;
    logic       load8, ready8, dataout8, frame8, busy8;

    int   checks   = 0;
    int   failures = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;

    always #5 clk = ~clk;

    piso_serializer #(
        .WIDTH     (4),
        .MSB_FIRST (1'b1),
        .GAP       (0)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .din     (din),
        .load    (load),
        .ready   (ready),
        .dataout (dataout),
        .frame   (frame),
        .busy    (busy)
    );

    piso_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0),
        .GAP       (2)
    ) dut8 (
        .clk     (clk),
        .clear   (clear),
        .din     (din8),
        .load    (load8),
        .ready   (ready8),
        .dataout (dataout8),
        .frame   (frame8),
        .busy    (busy8)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push4(input logic [3:0] w);
        exp_t e;
        for (int i = 3; i >= 0; i--) begin
            e.b = w[i];
            e.f = (i == 3);
            q4.push_back(e);
        end
    endtask

    task automatic push8(input logic [7:0] w);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b = w[i];
            e.f = (i == 0);
            q8.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain4(input int max_cycles);
        int n;
        n = 0;
        while ((q4.size() != 0 || busy) && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq("drain4_left", q4.size(), 0);
        check_eq("drain4_busy", busy, 0);
    endtask

    task automatic drain8(input int max_cycles);
        int n;
        n = 0;
        while ((q8.size() != 0 || busy8) && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq("drain8_left", q8.size(), 0);
        check_eq("drain8_busy", busy8, 0);
    endtask

    always @(negedge clk) begin
        if (!clear) begin
            if (busy) begin
                if (q4.size() == 0) begin
                    check_eq("dut4_unexpected_bit", busy, 0);
                end else begin
                    e4 = q4.pop_front();
                    check_eq("dut4_bit", dataout, e4.b);
                    check_eq("dut4_frame", frame, e4.f);
                end
            end else begin
                check_eq("dut4_idle", {dataout, frame}, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!clear) begin
            if (busy8) begin
                if (q8.size() == 0) begin
                    check_eq("dut8_unexpected_bit", busy8, 0);
                end else begin
                    e8 = q8.pop_front();
                    check_eq("dut8_bit", dataout8, e8.b);
                    check_eq("dut8_frame", frame8, e8.f);
                end
            end else begin
                check_eq("dut8_idle", {dataout8, frame8}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset held with a pending load: nothing may be accepted or driven.
        clear = 1'b1;
        load  = 1'b1;
        din   = 4'hF;
        load8 = 1'b1;
        din8  = 8'hFF;
        repeat (3) begin
            tick();
            check_eq("rst_dataout", dataout, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_frame", frame, 0);
            check_eq("rst_ready", ready, 1);
            check_eq("rst_ready8", ready8, 1);
        end
        load  = 1'b0;
        load8 = 1'b0;
        clear = 1'b0;
        repeat (3) tick();
        check_eq("post_rst_busy", busy, 0);

        // Single word, MSB first, one-cycle latency to first bit.
        check_eq("t2_ready", ready, 1);
        din  = 4'b1011;
        load = 1'b1;
        push4(4'b1011);
        tick();
        load = 1'b0;
        check_eq("t2_busy_n", busy, 0);
        check_eq("t2_ready_n", ready, 0);
        tick();
        check_eq("t2_busy_n1", busy, 1);
        check_eq("t2_frame_n1", frame, 1);
        check_eq("t2_bit_n1", dataout, 1);
        drain4(20);

        // Back-to-back words with the second staged during transmission.
        check_eq("t3_ready_a", ready, 1);
        din  = 4'hA;
        load = 1'b1;
        push4(4'hA);
        tick();
        load = 1'b0;
        tick();
        check_eq("t3_ready_staging", ready, 1);
        din  = 4'h5;
        load = 1'b1;
        push4(4'h5);
        tick();
        load = 1'b0;
        check_eq("t3_busy", busy, 1);
        repeat (6) begin
            tick();
            check_eq("t3_busy", busy, 1);
        end
        tick();
        check_eq("t3_end_busy", busy, 0);
        drain4(5);

        // Backpressure: loads while full are ignored.
        din  = 4'h3;
        load = 1'b1;
        check_eq("t4_ready_3", ready, 1);
        push4(4'h3);
        tick();
        din = 4'h9;
        check_eq("t4_ready_refuse", ready, 0);
        tick();
        din = 4'hC;
        check_eq("t4_ready_c", ready, 1);
        push4(4'hC);
        tick();
        din = 4'h9;
        check_eq("t4_ready_9", ready, 0);
        tick();
        load = 1'b0;
        drain4(20);

        // Clear mid-word with a second word buffered.
        din  = 4'hE;
        load = 1'b1;
        push4(4'hE);
        tick();
        load = 1'b0;
        tick();
        din  = 4'h1;
        load = 1'b1;
        tick();
        load = 1'b0;
        check_eq("t5_buffered", ready, 0);
        @(negedge clk);
        #1;
        clear = 1'b1;
        #1;
        q4.delete();
        check_eq("t5_clr_dataout", dataout, 0);
        check_eq("t5_clr_busy", busy, 0);
        check_eq("t5_clr_frame", frame, 0);
        check_eq("t5_clr_ready", ready, 1);
        tick();
        clear = 1'b0;
        repeat (10) tick();
        check_eq("t5_no_residual", busy, 0);
        check_eq("t5_ready_after", ready, 1);

        // WIDTH=8, LSB first, two idle cycles between words.
        din8  = 8'h81;
        load8 = 1'b1;
        check_eq("t6_ready", ready8, 1);
        push8(8'h81);
        tick();
        load8 = 1'b0;
        tick();
        check_eq("t6_first_frame", frame8, 1);
        check_eq("t6_first_busy", busy8, 1);
        din8  = 8'h55;
        load8 = 1'b1;
        check_eq("t6_ready_staging", ready8, 1);
        push8(8'h55);
        tick();
        load8 = 1'b0;
        repeat (6) tick();
        check_eq("t6_last_busy", busy8, 1);
        tick();
        check_eq("t6_gap1_busy", busy8, 0);
        check_eq("t6_gap1_data", dataout8, 0);
        tick();
        check_eq("t6_gap2_busy", busy8, 0);
        check_eq("t6_gap2_data", dataout8, 0);
        tick();
        check_eq("t6_next_frame", frame8, 1);
        drain8(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
